seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan_pkg.sv | 36 +++
 rtl/seg7_scan_hex7_decode.sv | 11 +
 rtl/seg7_scan.sv | 99 +++++++++
 tb/tb_seg7_scan.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: per-digit byte
// layout and the hex-to-segment table (active-high, gfedcba in bits 6..0).
package seg7_scan_pkg;

  // Byte layout: [3:0] hex value, [4] blank, [6:5] reserved, [7] decimal point.
  typedef struct packed {
    logic       dp;
    logic [1:0] rsvd;
    logic       blank;
    logic [3:0] hex;
  } digit_t;

  function automatic logic [6:0] hex7(input logic [3:0] value);
    logic [6:0] segs;
    case (value)
      4'h0:    segs = 7'h3F;
      4'h1:    segs = 7'h06;
      4'h2:    segs = 7'h5B;
      4'h3:    segs = 7'h4F;
      4'h4:    segs = 7'h66;
      4'h5:    segs = 7'h6D;
      4'h6:    segs = 7'h7D;
      4'h7:    segs = 7'h07;
      4'h8:    segs = 7'h7F;
      4'h9:    segs = 7'h6F;
      4'hA:    segs = 7'h77;
      4'hB:    segs = 7'h7C;
      4'hC:    segs = 7'h39;
      4'hD:    segs = 7'h5E;
      4'hE:    segs = 7'h79;
      default: segs = 7'h71;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/seg7_scan_hex7_decode.sv
// Purely combinational hex digit to active-high segment decoder.
module hex7_decode
  import seg7_scan_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] segments
);

  assign segments = hex7(value);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment scanner: one slot of PRESCALE cycles per digit,
// a dead-time gap at the start of each slot, and a per-frame snapshot of data_in.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 1000,
  parameter int DEADTIME   = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS*8-1:0]   data_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // XOR masks that turn active-high internal values into pin polarity.
  localparam logic              POL    = (ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{POL}};
  localparam logic [6:0]        SEG_OFF = {7{POL}};

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [DIGITS*8-1:0] shadow;

  logic cnt_wrap;
  logic idx_wrap;
  logic load;

  assign cnt_wrap = (cnt == CNT_W'(PRESCALE - 1));
  assign idx_wrap = (idx == IDX_W'(DIGITS - 1));
  assign load     = (cnt == '0) && (idx == '0);

  digit_t     sel;
  logic [6:0] dec_seg;
  logic       unused_rsvd;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) sel = shadow[i*8 +: 8];
    end
  end

  assign unused_rsvd = ^sel.rsvd;

  hex7_decode u_decode (
    .value    (sel.hex),
    .segments (dec_seg)
  );

  logic [DIGITS-1:0] an_next;
  logic [6:0]        seg_next;
  logic              dp_next;

  // Active-high view of the next pin state; the dead-time gap keeps every anode off.
  always_comb begin
    an_next  = '0;
    seg_next = '0;
    dp_next  = 1'b0;
    if (cnt >= CNT_W'(DEADTIME)) begin
      for (int i = 0; i < DIGITS; i++) an_next[i] = (idx == IDX_W'(i));
      if (!sel.blank) begin
        seg_next = dec_seg;
        dp_next  = sel.dp;
      end
    end
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, so it is only
  // seen on a clock edge, and the shadow register is cleared along with everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      frame  <= 1'b0;
      an     <= AN_OFF;
      seg    <= SEG_OFF;
      dp     <= POL;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap) idx <= idx_wrap ? '0 : idx + 1'b1;
      if (load) shadow <= data_in;
      frame <= load;
      an    <= an_next ^ AN_OFF;
      seg   <= seg_next ^ SEG_OFF;
      dp    <= dp_next ^ POL;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: an active-low and an active-high build run
// side by side on the same stimulus, with 4 digits, 8-cycle slots, 2-cycle dead time.
module tb_seg7_scan;

  localparam int DIGITS    = 4;
  localparam int PRESCALE  = 8;
  localparam int DEADTIME  = 2;
  localparam int FRAME_LEN = DIGITS * PRESCALE;

  localparam logic [6:0] HEX_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = '0;

  logic [6:0] seg_al, seg_ah;
  logic       dp_al, dp_ah;
  logic [3:0] an_al, an_ah;
  logic       frame_al, frame_ah;

  seg7_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEADTIME(DEADTIME), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .reset(reset), .data_in(data_in),
    .seg(seg_al), .dp(dp_al), .an(an_al), .frame(frame_al)
  );

  seg7_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEADTIME(DEADTIME), .ACTIVE_LOW(0)) dut_ah (
    .clk(clk), .reset(reset), .data_in(data_in),
    .seg(seg_ah), .dp(dp_ah), .an(an_ah), .frame(frame_ah)
  );

  always #5 clk = ~clk;

  // Active-high expectation for one output sample.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          k = 0;           // cycles since reset release; next edge's cycle number
  logic [31:0] sb_shadow = '0;  // bench copy of the frame snapshot

  function automatic exp_t expect_for(int kk, logic [31:0] sh);
    exp_t       e;
    int         c;
    int         d;
    logic [7:0] b;
    e       = '0;
    c       = kk % PRESCALE;
    d       = (kk / PRESCALE) % DIGITS;
    e.frame = ((kk % FRAME_LEN) == 0);
    if (c >= DEADTIME) begin
      e.an = 4'(1 << d);
      b    = sh[d*8 +: 8];
      if (!b[4]) begin
        e.seg = HEX_TBL[b[3:0]];
        e.dp  = b[7];
      end
    end
    return e;
  endfunction

  // One clock: push the expectation, let the edge happen, pop and compare both builds.
  task automatic step();
    exp_t e;
    if (reset) begin
      e         = '0;
      k         = 0;
      sb_shadow = '0;
    end else begin
      e = expect_for(k, sb_shadow);
      if ((k % FRAME_LEN) == 0) sb_shadow = data_in;
      k++;
    end
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    total++;
    if ({an_ah, seg_ah, dp_ah, frame_ah} !== {e.an, e.seg, e.dp, e.frame}) begin
      bad++;
      $display("FAIL sb_active_high k=%0d got an=%h seg=%h dp=%b frame=%b want an=%h seg=%h dp=%b frame=%b",
               k, an_ah, seg_ah, dp_ah, frame_ah, e.an, e.seg, e.dp, e.frame);
    end
    total++;
    if ({an_al, seg_al, dp_al, frame_al} !== {~e.an, ~e.seg, ~e.dp, e.frame}) begin
      bad++;
      $display("FAIL sb_active_low k=%0d got an=%h seg=%h dp=%b frame=%b want an=%h seg=%h dp=%b frame=%b",
               k, an_al, seg_al, dp_al, frame_al, ~e.an, ~e.seg, ~e.dp, e.frame);
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(logic [31:0] d);
    data_in = d;
    reset   = 1'b1;
    step();
    reset   = 1'b0;
  endtask

  task automatic test_reset();
    data_in = 32'h0;
    reset   = 1'b1;
    run(3);
    total++;
    if ({an_al, seg_al, dp_al, frame_al} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got an=%h seg=%h dp=%b frame=%b want an=f seg=7f dp=1 frame=0",
               an_al, seg_al, dp_al, frame_al);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    int act [4];
    int frames;
    int last_frame;
    int gap_bad;
    for (int d = 0; d < 4; d++) act[d] = 0;
    frames = 0; last_frame = -1; gap_bad = 0;
    do_reset(32'h03020100);
    for (int n = 0; n < 2 * FRAME_LEN; n++) begin
      step();
      for (int d = 0; d < 4; d++) if (an_al == ~(4'b0001 << d)) act[d]++;
      if (frame_al) begin
        if (last_frame >= 0 && (n - last_frame) != FRAME_LEN) gap_bad++;
        last_frame = n;
        frames++;
      end
    end
    for (int d = 0; d < 4; d++) begin
      total++;
      if (act[d] != 12) begin
        bad++;
        $display("FAIL scan_active_cycles digit=%0d got=%0d want=12", d, act[d]);
      end
    end
    total++;
    if (frames != 2 || gap_bad != 0) begin
      bad++;
      $display("FAIL scan_frame_pulses got frames=%0d gap_errors=%0d want frames=2 gap_errors=0", frames, gap_bad);
    end
  endtask

  task automatic test_snapshot();
    int early_f;
    int late_f;
    early_f = 0; late_f = 0;
    do_reset(32'h03020100);
    run(12);
    data_in = 32'h0F0F0F0F;
    for (int n = 12; n < 2 * FRAME_LEN; n++) begin
      step();
      if (seg_al == ~7'h71) begin
        if (n < FRAME_LEN) early_f++;
        else late_f++;
      end
    end
    total++;
    if (early_f != 0) begin
      bad++;
      $display("FAIL snapshot_tearing got F-cycles=%0d in current frame want 0", early_f);
    end
    total++;
    if (late_f != 24) begin
      bad++;
      $display("FAIL snapshot_next_frame got F-cycles=%0d want 24", late_f);
    end
  endtask

  task automatic test_blank_dp();
    do_reset(32'h00000095);
    run(5);  // samples 0..4: sample 4 is digit 0, past dead time
    total++;
    if ({an_al, seg_al, dp_al} !== {4'hE, 7'h7F, 1'b1}) begin
      bad++;
      $display("FAIL blank_digit got an=%h seg=%h dp=%b want an=e seg=7f dp=1", an_al, seg_al, dp_al);
    end
    data_in = 32'h00000085;
    run(FRAME_LEN);  // lands on sample 36: next frame, digit 0
    total++;
    if ({an_al, seg_al, dp_al} !== {4'hE, 7'h12, 1'b0}) begin
      bad++;
      $display("FAIL dp_digit got an=%h seg=%h dp=%b want an=e seg=12 dp=0", an_al, seg_al, dp_al);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(32'h03020100);
    run(21);  // next edge is idx=2, cnt=5
    total++;
    if (an_al !== 4'hB || seg_al !== ~7'h5B) begin
      bad++;
      $display("FAIL mid_before got an=%h seg=%h want an=b seg=24", an_al, seg_al);
    end
    data_in = 32'h0F0F0F0F;
    reset   = 1'b1;
    step();
    total++;
    if ({an_al, seg_al, dp_al, frame_al} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset got an=%h seg=%h dp=%b frame=%b want an=f seg=7f dp=1 frame=0",
               an_al, seg_al, dp_al, frame_al);
    end
    reset = 1'b0;
    step();
    total++;
    if (frame_al !== 1'b1) begin
      bad++;
      $display("FAIL mid_restart_frame got frame=%b want 1", frame_al);
    end
    run(2);
    total++;
    if (an_al !== 4'hE || seg_al !== ~7'h71) begin
      bad++;
      $display("FAIL mid_reload got an=%h seg=%h want an=e seg=0e", an_al, seg_al);
    end
  endtask

  task automatic test_active_high_build();
    logic [3:0] want_an  [4];
    logic [6:0] want_seg [4];
    want_an  = '{4'h1, 4'h2, 4'h4, 4'h8};
    want_seg = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    do_reset(32'h03020100);
    for (int d = 0; d < 4; d++) begin
      run((d == 0) ? 5 : PRESCALE);  // mid-slot sample of digit d
      total++;
      if (an_ah !== want_an[d] || seg_ah !== want_seg[d]) begin
        bad++;
        $display("FAIL active_high_digit%0d got an=%h seg=%h want an=%h seg=%h",
                 d, an_ah, seg_ah, want_an[d], want_seg[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_blank_dp();
    test_reset_mid();
    test_active_high_build();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
